// File: rtl/mips_alu_pkg.sv
// Shared MIPS/ALU definitions: ALU select codes, opcode/funct values and
// the operand-mux selects used between the decoder and the issue stage.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_XNOR = 4'b0101;
  localparam logic [3:0] ALU_SRL1 = 4'b0110;
  localparam logic [3:0] ALU_SLL1 = 4'b0111;
  localparam logic [3:0] ALU_SRLV = 4'b1000;
  localparam logic [3:0] ALU_SLLV = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef enum logic [1:0] {
    OP1_ZERO,
    OP1_RS,
    OP1_RT
  } op1_sel_e;

  typedef enum logic [2:0] {
    OP2_ZERO,
    OP2_RS,
    OP2_RT,
    OP2_SIMM,
    OP2_ZIMM,
    OP2_SHAMT,
    OP2_RS5
  } op2_sel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID/EX issue bus: decoded instruction in, registered ALU select/operands out.
// master = surrounding pipeline, slave = the issue stage.
interface alu_issue_stage_if #(parameter int DWL = 32);
  logic           in_valid;
  logic           in_ready;
  logic [5:0]     opcode;
  logic [5:0]     funct;
  logic [4:0]     shamt;
  logic [15:0]    imm;
  logic [DWL-1:0] rs_data;
  logic [DWL-1:0] rt_data;
  logic           out_ready;
  logic           flush;
  logic           out_valid;
  logic [3:0]     ALU_sel;
  logic [DWL-1:0] Din1;
  logic [DWL-1:0] Din2;
  logic           illegal;
  logic           is_branch;

  modport master (
    output in_valid, opcode, funct, shamt, imm, rs_data, rt_data, out_ready, flush,
    input  in_ready, out_valid, ALU_sel, Din1, Din2, illegal, is_branch
  );

  modport slave (
    input  in_valid, opcode, funct, shamt, imm, rs_data, rt_data, out_ready, flush,
    output in_ready, out_valid, ALU_sel, Din1, Din2, illegal, is_branch
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decode into ALU select, operand-mux
// selects, illegal and branch flags.
module alu_op_decode
  import mips_alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_sel,
  output op1_sel_e   op1_sel,
  output op2_sel_e   op2_sel,
  output logic       illegal,
  output logic       is_branch
);

  // Illegal encodings fall through to AND with zero operands.
  always_comb begin
    alu_sel   = ALU_AND;
    op1_sel   = OP1_ZERO;
    op2_sel   = OP2_ZERO;
    illegal   = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin alu_sel = ALU_ADD;  op1_sel = OP1_RS; op2_sel = OP2_RT;    end
          FN_SUB, FN_SUBU: begin alu_sel = ALU_SUB;  op1_sel = OP1_RT; op2_sel = OP2_RS;    end
          FN_AND:          begin alu_sel = ALU_AND;  op1_sel = OP1_RS; op2_sel = OP2_RT;    end
          FN_OR:           begin alu_sel = ALU_OR;   op1_sel = OP1_RS; op2_sel = OP2_RT;    end
          FN_XOR:          begin alu_sel = ALU_XOR;  op1_sel = OP1_RS; op2_sel = OP2_RT;    end
          FN_SLL:          begin alu_sel = ALU_SLLV; op1_sel = OP1_RT; op2_sel = OP2_SHAMT; end
          FN_SRL:          begin alu_sel = ALU_SRLV; op1_sel = OP1_RT; op2_sel = OP2_SHAMT; end
          FN_SRA:          begin alu_sel = ALU_SRAV; op1_sel = OP1_RT; op2_sel = OP2_SHAMT; end
          FN_SLLV:         begin alu_sel = ALU_SLLV; op1_sel = OP1_RT; op2_sel = OP2_RS5;   end
          FN_SRLV:         begin alu_sel = ALU_SRLV; op1_sel = OP1_RT; op2_sel = OP2_RS5;   end
          FN_SRAV:         begin alu_sel = ALU_SRAV; op1_sel = OP1_RT; op2_sel = OP2_RS5;   end
          default:         illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
        alu_sel = ALU_ADD; op1_sel = OP1_RS; op2_sel = OP2_SIMM;
      end
      OPC_ANDI: begin alu_sel = ALU_AND; op1_sel = OP1_RS; op2_sel = OP2_ZIMM; end
      OPC_ORI:  begin alu_sel = ALU_OR;  op1_sel = OP1_RS; op2_sel = OP2_ZIMM; end
      OPC_XORI: begin alu_sel = ALU_XOR; op1_sel = OP1_RS; op2_sel = OP2_ZIMM; end
      // The ALU subtracts Din2-Din1, so branches feed rt first and test zero.
      OPC_BEQ, OPC_BNE: begin
        alu_sel = ALU_SUB; op1_sel = OP1_RT; op2_sel = OP2_RS; is_branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU: one-deep valid/ready stage with
// flush, operand ordering and a saturating count of illegal encodings.
module alu_issue_stage
  import mips_alu_pkg::*;
#(
  parameter int DWL  = 32,
  parameter int CNTW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  alu_issue_stage_if.slave  bus,
  output logic [CNTW-1:0]   illegal_cnt
);

  logic [3:0] dec_sel;
  op1_sel_e   dec_op1;
  op2_sel_e   dec_op2;
  logic       dec_illegal;
  logic       dec_branch;

  alu_op_decode u_decode (
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .alu_sel   (dec_sel),
    .op1_sel   (dec_op1),
    .op2_sel   (dec_op2),
    .illegal   (dec_illegal),
    .is_branch (dec_branch)
  );

  logic            out_valid_q, out_valid_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic [DWL-1:0]  din1_q, din1_d;
  logic [DWL-1:0]  din2_q, din2_d;
  logic            illegal_q, illegal_d;
  logic            is_branch_q, is_branch_d;
  logic [CNTW-1:0] illegal_cnt_q, illegal_cnt_d;
  logic [DWL-1:0]  op1_val, op2_val;
  logic            in_ready;
  logic            accept;

  always_comb begin
    case (dec_op1)
      OP1_RS:  op1_val = bus.rs_data;
      OP1_RT:  op1_val = bus.rt_data;
      default: op1_val = '0;
    endcase
    case (dec_op2)
      OP2_RS:    op2_val = bus.rs_data;
      OP2_RT:    op2_val = bus.rt_data;
      OP2_SIMM:  op2_val = {{(DWL-16){bus.imm[15]}}, bus.imm};
      OP2_ZIMM:  op2_val = {{(DWL-16){1'b0}}, bus.imm};
      OP2_SHAMT: op2_val = {{(DWL-5){1'b0}}, bus.shamt};
      OP2_RS5:   op2_val = {{(DWL-5){1'b0}}, bus.rs_data[4:0]};
      default:   op2_val = '0;
    endcase
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Flush wins over accept; a plain retire only drops valid and keeps data.
  always_comb begin
    out_valid_d   = out_valid_q;
    alu_sel_d     = alu_sel_q;
    din1_d        = din1_q;
    din2_d        = din2_q;
    illegal_d     = illegal_q;
    is_branch_d   = is_branch_q;
    illegal_cnt_d = illegal_cnt_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
      is_branch_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_sel_d   = dec_sel;
      din1_d      = op1_val;
      din2_d      = op2_val;
      illegal_d   = dec_illegal;
      is_branch_d = dec_branch;
      if (dec_illegal && (illegal_cnt_q != {CNTW{1'b1}})) begin
        illegal_cnt_d = illegal_cnt_q + 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q   <= 1'b0;
      alu_sel_q     <= ALU_AND;
      din1_q        <= '0;
      din2_q        <= '0;
      illegal_q     <= 1'b0;
      is_branch_q   <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      alu_sel_q     <= alu_sel_d;
      din1_q        <= din1_d;
      din2_q        <= din2_d;
      illegal_q     <= illegal_d;
      is_branch_q   <= is_branch_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_sel   = alu_sel_q;
  assign bus.Din1      = din1_q;
  assign bus.Din2      = din2_q;
  assign bus.illegal   = illegal_q;
  assign bus.is_branch = is_branch_q;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary block that drives the pipeline ALU: registers one decoded MIPS instruction and emits the ALU select code and ordered operands the ALU expects.
- It is the producer side of the ALU operand/select interface, one pipeline stage of latency.
- Handles valid/ready flow control, stall, and flush.
- Flags encodings the ALU cannot execute and counts them.

Parameters:
- DWL, 32, datapath width; must match the ALU.
- CNTW, 16, width of the saturating illegal-op counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- shamt  in  5  instr[10:6].
- imm  in  16  instr[15:0].
- rs_data  in  DWL  forwarded rs value.
- rt_data  in  DWL  forwarded rt value.
- out_ready  in  1  EX stage can take the registered op; low = stall.
- flush  in  1  kill held op and the incoming op.
- out_valid  out  1  registered op valid.
- ALU_sel  out  4  ALU select code.
- Din1  out  DWL  ALU operand 1.
- Din2  out  DWL  ALU operand 2.
- illegal  out  1  registered op has an unsupported encoding.
- is_branch  out  1  registered op is BEQ/BNE; EX uses ALU zero.
- illegal_cnt  out  CNTW  saturating count of accepted illegal ops.

Behaviour:
- Reset (async, RST=1):
  - out_valid=0, ALU_sel=4'b0000, Din1=0, Din2=0, illegal=0, is_branch=0, illegal_cnt=0.
  - Reset asserted mid-operation discards the held op immediately.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready && !flush; outputs update on the next CLK edge (latency 1).
  - out_valid && !out_ready: all outputs hold stable.
  - Held op retires on out_valid && out_ready. With no new accept, out_valid falls to 0 next cycle; data outputs keep their last value.
- flush has priority over everything except RST. Next edge: out_valid=0, illegal=0, is_branch=0, incoming op dropped, illegal_cnt unchanged.
- Decode, R-type (opcode 0x00):
  - 0x20/0x21 -> 0010, Din1=rs, Din2=rt.
  - 0x22/0x23 -> 0011, Din1=rt, Din2=rs. The ALU computes Din2-Din1, so the result is rs-rt.
  - 0x24 -> 0000, 0x25 -> 0001, 0x26 -> 0100; Din1=rs, Din2=rt.
  - 0x00 -> 1001, 0x02 -> 1000, 0x03 -> 1010; Din1=rt, Din2=zero-extended shamt.
  - 0x04 -> 1001, 0x06 -> 1000, 0x07 -> 1010; Din1=rt, Din2=zero-extended rs[4:0].
  - Any other funct, including NOR 0x27 -> illegal.
- Decode, I-type:
  - addi 0x08 / addiu 0x09 / lw 0x23 / sw 0x2B -> 0010; Din1=rs, Din2=sign-extended imm.
  - andi 0x0C -> 0000, ori 0x0D -> 0001, xori 0x0E -> 0100; Din2=zero-extended imm.
  - beq 0x04 / bne 0x05 -> 0011, Din1=rt, Din2=rs, is_branch=1.
  - Any other opcode -> illegal.
- Illegal op:
  - Still accepted and issued with out_valid=1, illegal=1, ALU_sel=0000, Din1=Din2=0.
  - illegal_cnt increments on accept, saturating at all-ones with no wrap.
  - Simultaneous flush and illegal accept: no increment.
- Never emitted: codes 0101, 0110, 0111, 1011-1111.

Decomposition:
- Shared package mips_alu_pkg holds:
  - ALU_sel localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_XNOR, ALU_SRL1, ALU_SLL1, ALU_SRLV, ALU_SLLV, ALU_SRAV.
  - Opcode and funct constants.
- The ALU, this block, and the control unit all import the package.
- One sub-module: alu_op_decode, purely combinational opcode/funct -> sel, operand-mux selects, illegal, is_branch.
- The top holds the pipeline register, handshake, and counter.

Test Plan:
- Reset then R-type add (op 0x00, funct 0x20), rs=5, rt=7 -> next cycle out_valid=1, ALU_sel=0010, Din1=5, Din2=7.
- sub rs=10, rt=3 -> ALU_sel=0011, Din1=3, Din2=10; beq rs=rt=9 -> is_branch=1, Din1=Din2=9, and the ALU zero output is 1.
- addi imm=16'hFFFF, rs=4 -> Din2=32'hFFFFFFFF; ori imm=16'hFFFF -> Din2=32'h0000FFFF, ALU_sel=0001.
- sra shamt=4, rt=32'h80000000 -> ALU_sel=1010, Din1=32'h80000000, Din2=4; srav rs=32'h25 -> Din2=5.
- Hold out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs frozen; raise flush -> out_valid=0 next cycle, incoming op dropped.
- Feed 3 NOR ops (funct 0x27), one with flush high -> illegal=1 on the two issued ops, illegal_cnt=2; force counter to all-ones and feed another -> stays all-ones.
